// File: rtl/timing_pkg.sv
// Shared types and limits for the timing generator.
// Pure declarations, no logic or latency.
// No flow control; consumed by timing_gen and its interface.
package timing_pkg;

  // Timing controller states
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    HALTED  = 2'd2,
    STEP    = 2'd3
  } state_t;

  // Supported parameter ranges
  localparam int MAX_PHASES    = 8;
  localparam int MAX_BIT_TIMES = 64;

endpackage

// File: rtl/timing_gen_if.sv
// Control inputs and timing outputs of timing_gen, bundled as one port.
// Outputs are decodes of registered state (zero-cycle decode latency).
// No backpressure: en is the only throttle, it freezes the generator.
interface timing_gen_if #(
  parameter int PHASES    = 3,
  parameter int BIT_TIMES = 14
);
  localparam int BW = $clog2(BIT_TIMES);

  logic              en;
  logic              halt_req;
  logic              step;
  logic [PHASES-1:0] phase;
  logic [BW-1:0]     bit_time;
  logic              bit_last;
  logic              word_end;
  logic              running;
  logic              halted;
  logic              tmr_err;

  modport master (
    output en, halt_req, step,
    input  phase, bit_time, bit_last, word_end, running, halted, tmr_err
  );

  modport slave (
    input  en, halt_req, step,
    output phase, bit_time, bit_last, word_end, running, halted, tmr_err
  );
endinterface

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter with disagreement flag.
// Purely combinational, zero latency.
// No flow control.
module tmr_vote #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic             mismatch
);

  // Majority per bit; any copy differing from the others raises mismatch
  always_comb begin
    y        = (a & b) | (a & c) | (b & c);
    mismatch = (a != b) || (a != c);
  end

endmodule

// File: rtl/timing_gen.sv
// Multi-phase clock/bit-time generator with halt and single-step control.
// Outputs decode registered state with zero latency; one phase per enabled cycle.
// en low freezes every register; optional triplication under macro TIMING_TMR_EN.
module timing_gen
  import timing_pkg::*;
#(
  parameter int PHASES       = 3,
  parameter int BIT_TIMES    = 14,
  parameter int HALT_AT_WORD = 1
) (
  input  logic        clk,
  input  logic        rst,
  timing_gen_if.slave bus
);

  localparam int                BW       = $clog2(BIT_TIMES);
  localparam logic [BW-1:0]     LAST_BIT = BW'(BIT_TIMES - 1);
  localparam logic [PHASES-1:0] PH0      = PHASES'(1);

  // Current (voted, if triplicated) state and its next value
  logic [PHASES-1:0] phase_v, phase_nx;
  logic [BW-1:0]     bit_v, bit_nx;
  state_t            state_v, state_nx;
  logic              bit_last, word_end, boundary, adv;

  // Position decodes and the halt boundary selected by HALT_AT_WORD
  always_comb begin
    bit_last = phase_v[PHASES-1];
    word_end = bit_last && (bit_v == LAST_BIT);
    boundary = (HALT_AT_WORD != 0) ? word_end : bit_last;
  end

  // Next state and counter advance; with en low everything reloads its own value
  always_comb begin
    phase_nx = phase_v;
    bit_nx   = bit_v;
    state_nx = state_v;
    adv      = 1'b0;
    if (bus.en) begin
      unique case (state_v)
        RUN: begin
          adv = 1'b1;
          if (bus.halt_req) state_nx = boundary ? HALTED : HALTING;
        end
        HALTING: begin
          adv = 1'b1;
          if (!bus.halt_req)  state_nx = RUN;
          else if (boundary)  state_nx = HALTED;
        end
        HALTED: begin
          if (bus.halt_req && bus.step) state_nx = STEP;
          else if (!bus.halt_req)       state_nx = RUN;
        end
        STEP: begin
          adv = 1'b1;
          if (boundary) state_nx = HALTED;
        end
        default: state_nx = RUN;
      endcase
      if (adv) begin
        if (phase_v[PHASES-1]) begin
          phase_nx = PH0;
          bit_nx   = (bit_v == LAST_BIT) ? '0 : bit_v + BW'(1);
        end else begin
          phase_nx = phase_v << 1;
        end
      end
    end
  end

`ifdef TIMING_TMR_EN
  logic [PHASES-1:0]        phase_r0, phase_r1, phase_r2;
  logic [BW-1:0]            bit_r0, bit_r1, bit_r2;
  logic [$bits(state_t)-1:0] state_r0, state_r1, state_r2, state_vv;
  logic                     err_p, err_b, err_s;

  // All copies load the same voted next value, so a corrupted copy is scrubbed next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r0 <= PH0; phase_r1 <= PH0; phase_r2 <= PH0;
      bit_r0   <= '0;  bit_r1   <= '0;  bit_r2   <= '0;
      state_r0 <= RUN; state_r1 <= RUN; state_r2 <= RUN;
    end else begin
      phase_r0 <= phase_nx; phase_r1 <= phase_nx; phase_r2 <= phase_nx;
      bit_r0   <= bit_nx;   bit_r1   <= bit_nx;   bit_r2   <= bit_nx;
      state_r0 <= state_nx; state_r1 <= state_nx; state_r2 <= state_nx;
    end
  end

  tmr_vote #(.WIDTH(PHASES)) u_vote_phase (
    .a(phase_r0), .b(phase_r1), .c(phase_r2), .y(phase_v), .mismatch(err_p)
  );
  tmr_vote #(.WIDTH(BW)) u_vote_bit (
    .a(bit_r0), .b(bit_r1), .c(bit_r2), .y(bit_v), .mismatch(err_b)
  );
  tmr_vote #(.WIDTH($bits(state_t))) u_vote_state (
    .a(state_r0), .b(state_r1), .c(state_r2), .y(state_vv), .mismatch(err_s)
  );

  assign state_v     = state_t'(state_vv);
  assign bus.tmr_err = err_p | err_b | err_s;
`else
  // Single copy of the timing state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_v <= PH0;
      bit_v   <= '0;
      state_v <= RUN;
    end else begin
      phase_v <= phase_nx;
      bit_v   <= bit_nx;
      state_v <= state_nx;
    end
  end

  assign bus.tmr_err = 1'b0;
`endif

  assign bus.phase    = phase_v;
  assign bus.bit_time = bit_v;
  assign bus.bit_last = bit_last;
  assign bus.word_end = word_end;
  assign bus.running  = (state_v != HALTED);
  assign bus.halted   = (state_v == HALTED);

endmodule

// File: tb/tb_timing_gen.sv
// Directed bench for timing_gen: free run, halt, step, bit-boundary halt, async reset.
// Checks are taken on the falling edge, inputs change on the falling edge.
// Triplication checks compile only when TIMING_TMR_EN is defined.
module tb_timing_gen;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   cyc;

  timing_gen_if #(.PHASES(3), .BIT_TIMES(14)) bus ();
  timing_gen_if #(.PHASES(3), .BIT_TIMES(14)) bus2 ();

  timing_gen #(.PHASES(3), .BIT_TIMES(14), .HALT_AT_WORD(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  timing_gen #(.PHASES(3), .BIT_TIMES(14), .HALT_AT_WORD(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Hold reset over a couple of edges, check reset values, release on a falling edge
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_phase",   bus.phase,    32'h1);
    chk("rst_bit",     bus.bit_time, 32'h0);
    chk("rst_halted",  bus.halted,   32'h0);
    chk("rst_running", bus.running,  32'h1);
    chk("rst_tmr_err", bus.tmr_err,  32'h0);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int we_cnt;
    int we_first;
    int run_cnt;
    int halt_cnt;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    rst = 1'b1;
    bus.en = 1'b1;   bus.halt_req = 1'b0;  bus.step = 1'b0;
    bus2.en = 1'b1;  bus2.halt_req = 1'b0; bus2.step = 1'b0;

    // Free run: phase rotates 001,010,100; word_end at 41 and 83; step ignored in RUN
    do_reset();
    we_cnt = 0;
    we_first = -1;
    for (int n = 0; n < 100; n++) begin
      bus.step = (n == 20);
      chk($sformatf("run_phase@%0d", n), bus.phase, 32'(1 << (n % 3)));
      chk($sformatf("run_bit@%0d", n), bus.bit_time, 32'((n / 3) % 14));
      chk($sformatf("run_we@%0d", n), bus.word_end, 32'(n % 42 == 41));
      if (bus.word_end) begin
        we_cnt++;
        if (we_first < 0) we_first = n;
      end
      tick();
    end
    bus.step = 1'b0;
    chk("run_we_count", we_cnt, 2);
    chk("run_we_first", we_first, 41);

    // en low freezes counters at cycle 100 (phase 010, bit 5)
    bus.en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("frz_phase", bus.phase, 32'h2);
      chk("frz_bit", bus.bit_time, 32'd5);
    end
    bus.en = 1'b1;
    tick();
    chk("unfrz_phase", bus.phase, 32'h4);

    // Halt request at cycle 10 takes effect at the word boundary
    do_reset();
    for (int n = 0; n < 42; n++) begin
      bus.halt_req = (n >= 10);
      chk($sformatf("halting_run@%0d", n), bus.running, 32'h1);
      chk($sformatf("halting_hlt@%0d", n), bus.halted, 32'h0);
      if (n == 41) chk("halting_we41", bus.word_end, 32'h1);
      tick();
    end
    for (int n = 42; n < 46; n++) begin
      chk($sformatf("hlt_halted@%0d", n), bus.halted, 32'h1);
      chk($sformatf("hlt_running@%0d", n), bus.running, 32'h0);
      chk($sformatf("hlt_phase@%0d", n), bus.phase, 32'h1);
      chk($sformatf("hlt_bit@%0d", n), bus.bit_time, 32'h0);
      tick();
    end

    // Single step: one word of 42 advancing cycles, extra step pulse ignored
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    run_cnt = 0;
    we_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      bus.step = (n == 9);
      if (bus.running) run_cnt++;
      if (bus.word_end) we_cnt++;
      tick();
    end
    bus.step = 1'b0;
    chk("step_adv_cycles", run_cnt, 42);
    chk("step_word_ends", we_cnt, 1);
    chk("step_halted", bus.halted, 32'h1);
    chk("step_phase", bus.phase, 32'h1);
    chk("step_bit", bus.bit_time, 32'h0);

    // Step with en low is dropped
    bus.en = 1'b0;
    bus.step = 1'b1;
    tick();
    bus.en = 1'b1;
    bus.step = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("step_en0_halted", bus.halted, 32'h1);
      chk("step_en0_running", bus.running, 32'h0);
    end

    // Dropping halt_req resumes from phase 0 of bit 0
    bus.halt_req = 1'b0;
    tick();
    chk("resume_running", bus.running, 32'h1);
    chk("resume_phase0", bus.phase, 32'h1);
    tick();
    chk("resume_phase1", bus.phase, 32'h2);
    chk("resume_bit", bus.bit_time, 32'h0);

    // Halt request withdrawn before the boundary never halts
    do_reset();
    halt_cnt = 0;
    for (int n = 0; n < 50; n++) begin
      bus.halt_req = (n >= 5 && n < 8);
      if (bus.halted) halt_cnt++;
      tick();
    end
    bus.halt_req = 1'b0;
    chk("abort_halted_cycles", halt_cnt, 0);
    chk("abort_bit@50", bus.bit_time, 32'd2);

    // Bit-boundary halting: request at cycle 4, halts after cycle 5 with bit_time 2
    do_reset();
    for (int n = 0; n < 6; n++) begin
      bus2.halt_req = (n >= 4);
      if (n == 4) chk("hb_bitlast4", bus2.bit_last, 32'h0);
      if (n == 5) begin
        chk("hb_bitlast5", bus2.bit_last, 32'h1);
        chk("hb_running5", bus2.running, 32'h1);
      end
      tick();
    end
    chk("hb_halted", bus2.halted, 32'h1);
    chk("hb_bit", bus2.bit_time, 32'd2);
    chk("hb_phase", bus2.phase, 32'h1);
    tick();
    chk("hb_hold_bit", bus2.bit_time, 32'd2);
    bus2.halt_req = 1'b0;

    // Asynchronous reset mid-word (cycle 20, bit 6)
    do_reset();
    while (cyc < 20) tick();
    chk("ar_pre_bit", bus.bit_time, 32'd6);
    chk("ar_pre_phase", bus.phase, 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("ar_phase", bus.phase, 32'h1);
    chk("ar_bit", bus.bit_time, 32'h0);
    chk("ar_halted", bus.halted, 32'h0);
    chk("ar_bit_last", bus.bit_last, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    chk("ar_rel_phase", bus.phase, 32'h1);
    tick();
    chk("ar_c1_phase", bus.phase, 32'h2);
    chk("ar_c1_bit", bus.bit_time, 32'h0);

`ifdef TIMING_TMR_EN
    // Corrupt one bit_time copy: one-cycle error pulse, outputs unaffected, copy scrubbed
    do_reset();
    tick();
    force dut.bit_r1 = 4'd5;
    #1;
    chk("tmr_err_pulse", bus.tmr_err, 32'h1);
    chk("tmr_bit_voted", bus.bit_time, 32'h0);
    chk("tmr_phase", bus.phase, 32'h2);
    release dut.bit_r1;
    tick();
    chk("tmr_err_clear", bus.tmr_err, 32'h0);
    chk("tmr_phase_next", bus.phase, 32'h4);
    chk("tmr_copy_fixed", dut.bit_r1, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
